// File: rtl/shift_serializer_ctrl.sv
// rtl/shift_serializer_ctrl.sv - MSB-first parallel-to-serial transmitter with framing and idle gap
// Words arrive over a valid/ready handshake and leave one bit per clock on o_so.
module shift_serializer_ctrl #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2,
  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_din_valid,
  output logic             o_din_ready,
  input  logic             i_flush,
  output logic             o_so,
  output logic             o_so_valid,
  output logic             o_sof,
  output logic             o_eof,
  output logic             o_busy,
  output logic [CW-1:0]    o_bit_cnt
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] BIT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BIT_PENULT = CW'(WIDTH - 2);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bit_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_so_valid;
  logic             r_sof;
  logic             r_eof;
  logic             r_busy;

  logic w_last_bit;
  logic w_last_gap;
  logic w_din_ready;
  logic w_accept;

  assign w_last_bit = (r_state == ST_SHIFT) && (r_bit_cnt == BIT_LAST);
  assign w_last_gap = (r_state == ST_GAP) && (r_gap_cnt == GAP_LAST);

  // With no gap the last data bit doubles as the reload slot, giving bubble-free streaming.
  assign w_din_ready = !i_rst && !i_flush &&
                       ((r_state == ST_IDLE) || ((GAP == 0) ? w_last_bit : w_last_gap));
  assign w_accept    = i_din_valid && w_din_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_so_valid <= 1'b0;
      r_sof      <= 1'b0;
      r_eof      <= 1'b0;
      r_busy     <= 1'b0;
    end else if (w_accept) begin
      r_state    <= ST_SHIFT;
      r_shreg    <= i_din;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_so_valid <= 1'b1;
      r_sof      <= 1'b1;
      r_eof      <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      unique case (r_state)
        ST_SHIFT: begin
          // Zero fill leaves the register clear once the last bit has gone out.
          r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
          r_sof   <= 1'b0;
          if (w_last_bit) begin
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_so_valid <= 1'b0;
            r_eof      <= 1'b0;
            if (GAP == 0) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_GAP;
              r_busy  <= 1'b1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
            r_eof     <= (r_bit_cnt == BIT_PENULT);
          end
        end
        ST_GAP: begin
          if (w_last_gap) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
            r_busy    <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_din_ready = w_din_ready;
  assign o_so        = r_shreg[WIDTH-1];
  assign o_so_valid  = r_so_valid;
  assign o_sof       = r_sof;
  assign o_eof       = r_eof;
  assign o_busy      = r_busy;
  assign o_bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_shift_serializer_ctrl.sv
// tb/tb_shift_serializer_ctrl.sv - scoreboard bench for shift_serializer_ctrl with GAP=2 and GAP=0 instances
// Index 0 is the GAP=2 instance, index 1 the GAP=0 instance.
module tb_shift_serializer_ctrl;

  localparam int W     = 8;
  localparam int NSLOT = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst[2];
  logic         flush[2];
  logic         din_valid[2];
  logic [W-1:0] din[2];
  logic         ready[2];
  logic         so[2];
  logic         so_valid[2];
  logic         sof[2];
  logic         eof[2];
  logic         busy[2];
  logic [2:0]   bit_cnt[2];

  shift_serializer_ctrl #(.WIDTH(W), .GAP(2)) u_gap2 (
    .i_clk(clk), .i_rst(rst[0]), .i_din(din[0]), .i_din_valid(din_valid[0]),
    .o_din_ready(ready[0]), .i_flush(flush[0]), .o_so(so[0]), .o_so_valid(so_valid[0]),
    .o_sof(sof[0]), .o_eof(eof[0]), .o_busy(busy[0]), .o_bit_cnt(bit_cnt[0])
  );

  shift_serializer_ctrl #(.WIDTH(W), .GAP(0)) u_gap0 (
    .i_clk(clk), .i_rst(rst[1]), .i_din(din[1]), .i_din_valid(din_valid[1]),
    .o_din_ready(ready[1]), .i_flush(flush[1]), .o_so(so[1]), .o_so_valid(so_valid[1]),
    .o_sof(sof[1]), .o_eof(eof[1]), .o_busy(busy[1]), .o_bit_cnt(bit_cnt[1])
  );

  int n_cmp = 0;
  int n_fail = 0;
  int n_timeouts = 0;
  bit done = 1'b0;

  // phase: 0 = no word in flight, otherwise cycles elapsed since the accepting edge.
  int phase[2] = '{0, 0};
  bit acc[2] = '{1'b0, 1'b0};
  logic [5:0] exp_mem[2][NSLOT];
  int wr[2] = '{0, 0};
  int rd[2] = '{0, 0};

  function automatic int gap_of(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit exp_ready(int d);
    return !rst[d] && !flush[d] && (phase[d] == 0 || phase[d] >= W + gap_of(d));
  endfunction

  task automatic check(string name, int d, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) acc[d] = din_valid[d] && exp_ready(d);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst[d] || flush[d]) begin
        phase[d] = 0;
      end else if (acc[d]) begin
        phase[d] = 1;
        for (int i = 0; i < W; i++) begin
          exp_mem[d][wr[d] % NSLOT] = {din[d][W-1-i], 1'(i == 0), 1'(i == W - 1), 3'(i)};
          wr[d]++;
        end
      end else if (phase[d] > 0) begin
        phase[d] = (phase[d] >= W + gap_of(d)) ? 0 : phase[d] + 1;
      end
    end
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic send(int d, logic [W-1:0] data);
    int n;
    n = 0;
    din[d] = data;
    din_valid[d] = 1'b1;
    do begin
      tick();
      n++;
    end while (!acc[d] && n < 200);
    if (!acc[d]) n_timeouts++;
  endtask

  initial begin
    logic exp_v;
    logic [5:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        exp_v = (phase[d] >= 1) && (phase[d] <= W);
        check("din_ready", d, ready[d], exp_ready(d));
        check("busy", d, busy[d], phase[d] > 0);
        check("so_valid", d, so_valid[d], exp_v);
        if (so_valid[d]) begin
          if (rd[d] == wr[d]) begin
            check("sb_nonempty", d, 32'(wr[d] - rd[d]), 32'(W));
          end else begin
            e = exp_mem[d][rd[d] % NSLOT];
            rd[d]++;
            check("so_sof_eof_cnt", d, {so[d], sof[d], eof[d], bit_cnt[d]}, e);
          end
        end else begin
          check("idle_outputs", d, {so[d], sof[d], eof[d], bit_cnt[d]}, 6'd0);
        end
        if (rst[d] || flush[d]) rd[d] = wr[d];
      end
      if (done) begin
        for (int d = 0; d < 2; d++) check("sb_drained", d, rd[d], wr[d]);
        check("send_timeouts", 0, n_timeouts, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d compared", n_cmp);
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      flush[d] = 1'b0;
      din_valid[d] = 1'b1;
      din[d] = W'($urandom);
    end
    run(3);
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0;
      din_valid[d] = 1'b0;
    end
    tick();

    send(0, 8'hB5);
    din_valid[0] = 1'b0;
    run(12);

    send(1, 8'hA5);
    send(1, 8'h3C);
    din_valid[1] = 1'b0;
    run(20);

    send(0, W'($urandom));
    send(0, W'($urandom));
    send(0, W'($urandom));
    din_valid[0] = 1'b0;
    run(15);

    send(0, 8'hFF);
    din_valid[0] = 1'b0;
    run(3);
    flush[0] = 1'b1;
    din_valid[0] = 1'b1;
    din[0] = 8'h7E;
    tick();
    flush[0] = 1'b0;
    din_valid[0] = 1'b0;
    tick();
    send(0, 8'h81);
    din_valid[0] = 1'b0;
    run(12);

    send(0, W'($urandom));
    din_valid[0] = 1'b0;
    run(8);
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    tick();
    send(0, 8'h01);
    din_valid[0] = 1'b0;
    run(12);

    for (int c = 0; c < 500; c++) begin
      for (int d = 0; d < 2; d++) begin
        rst[d] = ($urandom % 90) == 0;
        flush[d] = ($urandom % 40) == 0;
        din_valid[d] = ($urandom % 4) != 0;
        din[d] = W'($urandom);
      end
      tick();
    end
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0;
      flush[d] = 1'b0;
      din_valid[d] = 1'b0;
    end
    run(20);
    done = 1'b1;
  end

endmodule

// File: doc/shift_serializer_ctrl.md
Name: shift_serializer_ctrl

Overview:
- Controller that sequences a shift-left register as a parallel-to-serial transmitter.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts each word out MSB-first on `so`, one bit per clock.
- Marks frame boundaries and inserts a configurable idle gap between words.
- Sits between a word-producing block and any serial consumer of `so`.

Parameters:
- WIDTH, 8, bits per word (≥2).
- GAP, 2, idle cycles inserted after each word's last bit (0 allowed = continuous streaming).
- CW, $clog2(WIDTH), bit counter width (localparam-derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- din  input  WIDTH  parallel word to transmit
- din_valid  input  1  producer has a word on din
- din_ready  output  1  controller accepts din this cycle
- flush  input  1  synchronous abort of the current word/gap
- so  output  1  serial data out (MSB of internal shift register)
- so_valid  output  1  so carries a data bit this cycle
- sof  output  1  high with the first bit (din[WIDTH-1]) of a word
- eof  output  1  high with the last bit (din[0]) of a word
- busy  output  1  state != IDLE
- bit_cnt  output  CW  index of the bit currently on so (0 = MSB)

Behaviour:
- Clocking and reset:
  - Single clock. All state updates on the rising edge of clk; reset is synchronous, active-high.
  - Reset state is IDLE with shreg=0, bit_cnt=0 and gap counter=0.
  - Registered outputs during and after reset: so=0, so_valid=0, sof=0, eof=0, busy=0.
  - din_ready is a combinational decode of state, forced to 0 while rst or flush is high.
- States: IDLE, SHIFT, GAP.
- Handshake:
  - A word is accepted on any edge where din_valid & din_ready.
  - din is sampled only on that edge; din_valid may drop afterwards.
- din_ready is high in exactly these cases:
  - IDLE;
  - the final SHIFT cycle (bit_cnt==WIDTH-1) when GAP==0;
  - the final GAP cycle when GAP>0.
- Accept at edge ending cycle k:
  - shreg<=din, bit_cnt<=0, state<=SHIFT.
  - Cycle k+1 shows so=din[WIDTH-1], so_valid=1, sof=1.
- SHIFT:
  - Each edge: shreg<=shreg<<1 with zero fill, bit_cnt++.
  - so=shreg[WIDTH-1] throughout.
  - Bits occupy cycles k+1..k+WIDTH. eof=1 only in cycle k+WIDTH (bit_cnt==WIDTH-1).
- Leaving SHIFT after the last bit:
  - If GAP==0 and a word is accepted in the same cycle: reload and stay in SHIFT. The next cycle shows the new word's MSB with sof=1, so there are no bubble cycles.
  - If GAP==0 and no word is accepted: go to IDLE.
  - If GAP>0: go to GAP with gap counter=0.
- GAP:
  - so=0, so_valid=0, sof=0, eof=0, busy=1.
  - Stays exactly GAP cycles.
  - In the final gap cycle: accept → SHIFT, else → IDLE.
- Word period with din_valid held high: WIDTH+GAP cycles between consecutive sof pulses.
- bit_cnt wraps only via reload. It is held at 0 in IDLE/GAP and never exceeds WIDTH-1.
- flush:
  - From any state, the next state is IDLE with shreg=0 and bit_cnt=0.
  - so_valid, sof, eof are 0 from the next cycle; no eof is emitted for a truncated word.
  - flush dominates a simultaneous handshake: din_ready is 0, so no word is accepted.
- Reset mid-word behaves like flush and also clears all outputs.
- sof and eof never assert together (WIDTH≥2). so_valid=1 exactly when state==SHIFT.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 3 cycles with din_valid=1.
  - Required: din_ready=0 and all outputs 0 throughout; the first cycle after rst drops shows din_ready=1 and busy=0.
- Single word (WIDTH=8, GAP=2):
  - Stimulus: din=8'hB5 for one handshake.
  - Required: so=1,0,1,1,0,1,0,1 over 8 cycles; sof on bit 1, eof on bit 8; then 2 cycles so_valid=0, busy=1; then busy=0, din_ready=1.
- Streaming, GAP=0:
  - Stimulus: 8'hA5 then 8'h3C with din_valid held.
  - Required: 16 consecutive so_valid cycles (10100101 00111100); sof at cycles 1 and 9; eof at 8 and 16; din_ready high only in cycles 8 and 16 of the stream.
- Streaming, GAP=2:
  - Stimulus: three words with din_valid held.
  - Required: sof pulses exactly 10 cycles apart; so_valid low for exactly 2 cycles between words.
- flush mid-word:
  - Stimulus: flush after the 3rd bit of 8'hFF, with din_valid=1 in the same cycle.
  - Required: next cycle so_valid=0, busy=0, no eof, word not accepted; next handshake 8'h81 shifts cleanly with sof.
- Reset mid-GAP:
  - Stimulus: rst=1 during the 1st gap cycle.
  - Required: next cycle all outputs 0, state IDLE; a following word 8'h01 yields so=0×7 then 1 with eof.
